// File: rtl/dct_acc_pkg.sv
// rtl/dct_acc_pkg.sv - shared widths, rounding constant and coefficient type for the DCT accumulator
package dct_acc_pkg;

  localparam int COEF_W = 12;

  typedef logic signed [COEF_W-1:0] coef_t;

  // Accumulator width that cannot overflow when summing `terms` products of `prod_w` bits.
  function automatic int calc_acc_w(input int prod_w, input int terms);
    return prod_w + $clog2(terms);
  endfunction

  // Half an LSB of the output scale; added before the shift to round half up.
  function automatic longint round_const(input int frac_bits);
    return longint'(1) <<< (frac_bits - 1);
  endfunction

endpackage

// File: rtl/dct_round_sat.sv
// rtl/dct_round_sat.sv - round, shift and clamp (DCT_ACC_SAT_EN) or wrap a finished dot-product sum
module dct_round_sat
  import dct_acc_pkg::*;
#(
  parameter int ACC_W     = 22,
  parameter int FRAC_BITS = 8,
  parameter int OUT_W     = 12
) (
  input  logic [ACC_W-1:0] i_sum,
  output logic [OUT_W-1:0] o_coef
);

  localparam logic [ACC_W:0] RND = (ACC_W+1)'(round_const(FRAC_BITS));

  // One guard bit so adding the rounding constant to the largest sum cannot wrap.
  logic signed [ACC_W:0] w_biased;
  assign w_biased = {i_sum[ACC_W-1], i_sum} + RND;

`ifdef DCT_ACC_SAT_EN
  localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_V = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W:0] w_shift;
  assign w_shift = w_biased >>> FRAC_BITS;

  // Clamp the rounded value into the signed output range.
  always_comb begin
    o_coef = w_shift[OUT_W-1:0];
    if (w_shift > MAX_V) begin
      o_coef = MAX_V[OUT_W-1:0];
    end else if (w_shift < MIN_V) begin
      o_coef = MIN_V[OUT_W-1:0];
    end
  end
`else
  // Two's-complement wrap: keep only the low OUT_W bits of the rounded value.
  assign o_coef = OUT_W'(w_biased >>> FRAC_BITS);
`endif

endmodule

// File: rtl/dct_mac_accum.sv
// rtl/dct_mac_accum.sv - accumulate TERMS signed products into one rounded DCT coefficient (option: DCT_ACC_SAT_EN)
module dct_mac_accum
  import dct_acc_pkg::*;
#(
  parameter int PROD_W    = 19,
  parameter int TERMS     = 8,
  parameter int FRAC_BITS = 8,
  parameter int OUT_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              flush,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [OUT_W-1:0]  coef,
  output logic              coef_valid,
  input  logic              coef_ready
);

  localparam int ACC_W = calc_acc_w(PROD_W, TERMS);
  localparam int CNT_W = $clog2(TERMS);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_coef;
  logic             r_coef_valid;

  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W-1:0] w_sum;
  logic [OUT_W-1:0] w_round;
  logic             w_last;
  logic             w_accept;
  logic             w_xfer;

  assign w_prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign w_sum      = r_acc + w_prod_ext;
  assign w_last     = (r_cnt == CNT_W'(TERMS-1));

  // Input stalls whenever a finished coefficient is waiting and not being taken.
  assign prod_ready = ~rst & ena & (~r_coef_valid | coef_ready);
  // A flush discards the product offered in the same cycle.
  assign w_accept   = prod_valid & prod_ready & ~flush;
  assign w_xfer     = ena & r_coef_valid & coef_ready;

  assign coef       = r_coef;
  assign coef_valid = r_coef_valid;

  dct_round_sat #(
    .ACC_W    (ACC_W),
    .FRAC_BITS(FRAC_BITS),
    .OUT_W    (OUT_W)
  ) u_round_sat (
    .i_sum (w_sum),
    .o_coef(w_round)
  );

  // Partial-sum accumulation and output register; a final-term set beats a transfer clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_coef       <= '0;
      r_coef_valid <= 1'b0;
    end else if (ena) begin
      if (w_xfer) begin
        r_coef_valid <= 1'b0;
      end
      if (flush) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_accept) begin
        if (w_last) begin
          r_acc        <= '0;
          r_cnt        <= '0;
          r_coef       <= w_round;
          r_coef_valid <= 1'b1;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
